// File: rtl/usb_scb_controller_if.sv
// Side-channel control bus between the register controller and the FT1248 bridge.
interface usb_scb;
    logic        fifo_flush;
    logic        write_buffer_flush;
    logic        reset_on_ack;
    logic        reset_off_ack;
    logic        fifo_flush_busy;
    logic [10:0] rx_count;
    logic [10:0] tx_count;
    logic        pwrsav;
    logic        reset_state;

    modport controller (
        output fifo_flush, write_buffer_flush, reset_on_ack, reset_off_ack,
        input  fifo_flush_busy, rx_count, tx_count, pwrsav, reset_state
    );

    modport bridge (
        input  fifo_flush, write_buffer_flush, reset_on_ack, reset_off_ack,
        output fifo_flush_busy, rx_count, tx_count, pwrsav, reset_state
    );
endinterface

// File: rtl/usb_scb_controller.sv
// Register-mapped sequencer for FT1248 side-channel pulses: FIFO flush handshake,
// write-buffer flush (manual and idle-timer), reset-state ack, and a level interrupt.
module usb_scb_controller #(
    parameter int FLUSH_IDLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_address,
    input  logic        reg_write,
    input  logic        reg_read,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        irq,
    usb_scb.controller  usb_scb
);
    localparam int CW = $clog2(FLUSH_IDLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FLUSH_IDLE_CYCLES - 1);

    typedef enum logic [1:0] {FL_IDLE, FL_REQ, FL_WAIT_HI, FL_WAIT_LO} fl_state_e;

    fl_state_e   state_q, state_d;
    logic        fifo_flush_q, fifo_flush_d;
    logic        wbf_q, wbf_d;
    logic        on_ack_q, on_ack_d;
    logic        off_ack_q, off_ack_d;
    logic        irq_pend_q, irq_pend_d;
    logic        ack_pend_q, ack_pend_d;
    logic        rs_q, rs_d;
    logic        rs_prev_q, rs_prev_d;
    logic        armed_q, armed_d;
    logic        auto_en_q, auto_en_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic wr_ctrl, rs_edge, flush_done, ack_go, manual, auto_fire;
    logic [31:0] status_w, count_w;
    logic unused_wdata;

    assign unused_wdata = ^reg_wdata[31:5];

    always_comb begin
        wr_ctrl      = reg_write && !reg_address;
        rs_edge      = rs_q ^ rs_prev_q;
        state_d      = state_q;
        fifo_flush_d = 1'b0;
        flush_done   = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (wr_ctrl && reg_wdata[0]) begin
                    state_d      = FL_REQ;
                    fifo_flush_d = 1'b1;
                end
            end
            FL_REQ:     state_d = FL_WAIT_HI;
            FL_WAIT_HI: if (usb_scb.fifo_flush_busy) state_d = FL_WAIT_LO;
            FL_WAIT_LO: begin
                if (!usb_scb.fifo_flush_busy) begin
                    state_d    = FL_IDLE;
                    flush_done = 1'b1;
                end
            end
            default:    state_d = FL_IDLE;
        endcase

        // The ack consumes the current pending edge; a new edge this cycle re-arms it.
        ack_go     = wr_ctrl && reg_wdata[2] && ack_pend_q;
        on_ack_d   = ack_go && rs_q;
        off_ack_d  = ack_go && !rs_q;
        ack_pend_d = (ack_pend_q && !ack_go) || rs_edge;
        irq_pend_d = (irq_pend_q && !(wr_ctrl && reg_wdata[3])) || flush_done || rs_edge;
        rs_d       = usb_scb.reset_state;
        rs_prev_d  = rs_q;
        auto_en_d  = wr_ctrl ? reg_wdata[4] : auto_en_q;

        manual    = wr_ctrl && reg_wdata[1];
        auto_fire = 1'b0;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        if (usb_scb.tx_count != '0) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (manual) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (!auto_en_q) begin
            cnt_d = '0;
        end else if (armed_q) begin
            if (cnt_q == CNT_MAX) begin
                auto_fire = 1'b1;
                armed_d   = 1'b0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        wbf_d = manual || auto_fire;

        status_w = {25'd0, ack_pend_q, usb_scb.pwrsav, auto_en_q, irq_pend_q,
                    rs_q, armed_q, state_q != FL_IDLE};
        count_w  = {5'd0, usb_scb.tx_count, 5'd0, usb_scb.rx_count};
        rdata_d  = rdata_q;
        if (reg_read) rdata_d = reg_address ? count_w : status_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FL_IDLE;
            fifo_flush_q <= 1'b0;
            wbf_q        <= 1'b0;
            on_ack_q     <= 1'b0;
            off_ack_q    <= 1'b0;
            irq_pend_q   <= 1'b0;
            ack_pend_q   <= 1'b0;
            rs_q         <= 1'b0;
            rs_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            auto_en_q    <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            fifo_flush_q <= fifo_flush_d;
            wbf_q        <= wbf_d;
            on_ack_q     <= on_ack_d;
            off_ack_q    <= off_ack_d;
            irq_pend_q   <= irq_pend_d;
            ack_pend_q   <= ack_pend_d;
            rs_q         <= rs_d;
            rs_prev_q    <= rs_prev_d;
            armed_q      <= armed_d;
            auto_en_q    <= auto_en_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    assign usb_scb.fifo_flush         = fifo_flush_q;
    assign usb_scb.write_buffer_flush = wbf_q;
    assign usb_scb.reset_on_ack       = on_ack_q;
    assign usb_scb.reset_off_ack      = off_ack_q;
    assign reg_rdata                  = rdata_q;
    assign irq                        = irq_pend_q;
endmodule

// File: doc/usb_scb_controller.md
# usb_scb_controller

Register-mapped controller for the USB FT1248 bridge's side-channel control bus (`usb_scb`, controller modport). It turns CPU register writes into correctly sequenced single-cycle control pulses: FIFO flush, write-buffer flush and USB reset acknowledge. It tracks flush completion and USB reset-state edges, raises an interrupt, and runs an idle-timer auto flush of the FT1248 write buffer. It sits between the CPU register bus and the `usb_ft1248` instance.

## Interface
- `FLUSH_IDLE_CYCLES`, default 1024: idle cycles with `tx_count == 0` before an auto write-buffer flush. Must be ≥ 2. Counter width is `$clog2(FLUSH_IDLE_CYCLES)`.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reg_address`  in  1  0 = CTRL/STATUS, 1 = COUNT.
- `reg_write`  in  1  one-cycle write strobe.
- `reg_read`  in  1  one-cycle read strobe.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  registered read data.
- `irq`  out  1  level interrupt; high while `irq_pending`.
- `usb_scb`  modport `usb_scb.controller`, carrying:
  - outputs: `fifo_flush`, `write_buffer_flush`, `reset_on_ack`, `reset_off_ack`;
  - inputs: `fifo_flush_busy`, `rx_count[10:0]`, `tx_count[10:0]`, `pwrsav`, `reset_state`.

## Operation
- **CTRL write bits** (address 0; 1 = act, 0 = no-op):
  - [0] FIFO_FLUSH;
  - [1] WRITE_FLUSH;
  - [2] RESET_ACK;
  - [3] IRQ_CLEAR;
  - [4] AUTO_FLUSH_EN, which is stored (written every CTRL write).
- **STATUS read** (address 0):
  - [0] flush_busy;
  - [1] auto_flush_armed;
  - [2] reset_state;
  - [3] irq_pending;
  - [4] auto_flush_en;
  - [5] pwrsav;
  - [6] reset_ack_pending;
  - others 0.
- **COUNT read** (address 1): [26:16] tx_count, [10:0] rx_count, others 0.
- **Flush FSM**: FL_IDLE → FL_REQ → FL_WAIT_HI → FL_WAIT_LO → FL_IDLE.
  - FIFO_FLUSH in FL_IDLE goes to FL_REQ.
  - FL_REQ drives `fifo_flush` high for exactly one cycle.
  - FL_WAIT_HI waits for `fifo_flush_busy` = 1.
  - FL_WAIT_LO waits for `fifo_flush_busy` = 0, then sets irq_pending.
  - flush_busy = (state ≠ FL_IDLE).
  - FIFO_FLUSH while not in FL_IDLE is ignored.
- **Reset tracking**:
  - `reset_state` is registered once; any edge of the registered copy sets reset_ack_pending and irq_pending.
  - RESET_ACK with reset_ack_pending = 1 pulses `reset_on_ack` if registered reset_state = 1, else `reset_off_ack`, then clears reset_ack_pending.
  - RESET_ACK with no pending edge is ignored.
  - An edge in the same cycle as RESET_ACK: the ack is applied first, and the edge re-sets pending.
- **Auto flush**:
  - `tx_count ≠ 0` sets auto_flush_armed and clears the idle counter.
  - While armed, `auto_flush_en` = 1 and `tx_count == 0`, the counter increments.
  - At `FLUSH_IDLE_CYCLES-1` the block pulses `write_buffer_flush`, disarms and clears the counter.
  - `auto_flush_en` = 0 holds the counter at 0 but keeps the armed state.
- **Manual flush**: WRITE_FLUSH pulses `write_buffer_flush` and disarms. Manual and auto firing in the same cycle produce one pulse.
- **IRQ_CLEAR**: clears irq_pending. A set event in the same cycle wins.
- **Mid-operation reset**: `reset_n` low mid-flush returns the FSM to FL_IDLE and drops all pending flags.

## Timing
- **Reset values** (`reset_n` low, asynchronous):
  - all `usb_scb` outputs 0;
  - `reg_rdata` 0, `irq` 0;
  - FSM in FL_IDLE;
  - all pending and armed flags 0, auto_flush_en 0, counter 0.
- **Outputs**: all registered, no combinational path from the register bus.
- **Pulse latency**: a CTRL write in cycle N gives the pulse in cycle N+1.
  - Exception: `fifo_flush` is high in cycle N+1, since the write enters FL_REQ at N+1.
- **Pulse width**: every pulse output is exactly one cycle.
- **Read latency**: `reg_read` in cycle N gives `reg_rdata` valid in N+1, held until the next read.
- **Read/write collision**: a simultaneous read and write at the same address returns the pre-write value.
- **IRQ latency**:
  - `irq` rises one cycle after a reset_state edge reaches the register;
  - `irq` rises one cycle after `fifo_flush_busy` falls.

## Test plan
- **FIFO flush**: write CTRL = 0x1 at cycle 10; model raises busy at 12 and drops it at 20 → `fifo_flush` high only at 11; STATUS[0] = 1 over 11–20 and 0 at 21; `irq` = 1 at 21.
- **Flush ignored while busy**: write 0x1 twice, 3 cycles apart → exactly one `fifo_flush` pulse.
- **Reset handshake**:
  - `reset_state` 0→1 → STATUS[6] = 1 and `irq` = 1;
  - write 0x4 → single `reset_on_ack`, no `reset_off_ack`, STATUS[6] = 0;
  - `reset_state` 1→0 then write 0x4 → single `reset_off_ack`;
  - a third write 0x4 → no pulse.
- **Auto flush** (`FLUSH_IDLE_CYCLES` = 16, auto_flush_en = 1): `tx_count` = 5 then 0 → `write_buffer_flush` pulses once, 16 cycles after `tx_count` reaches 0; no further pulse while `tx_count` stays 0.
- **Manual vs auto collision**: WRITE_FLUSH written in the auto-fire cycle → one pulse only.
- **Reads and async reset**:
  - COUNT read with rx = 0x7FF, tx = 0x001 → `reg_rdata` = 0x000107FF;
  - `reset_n` low during FL_WAIT_LO → all outputs 0 immediately, FSM in FL_IDLE after release.
